// File: rtl/i2s_stereo_tx.sv
// Philips I2S stereo transmitter: pops the L/R sample FIFOs in lock-step once per
// frame and serialises both words MSB first with internally generated BCLK/LRCK.
module i2s_stereo_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] l_rd_data,
    input  logic                  l_empty,
    output logic                  l_rd_en,
    input  logic [DATA_WIDTH-1:0] r_rd_data,
    input  logic                  r_empty,
    output logic                  r_rd_en,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);
    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DW       = BIT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT, RD, LATCH} state_t;

    state_t                state, state_nxt;
    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [BIT_W-1:0]      pos;
    logic [DATA_WIDTH-1:0] l_word, r_word, word;
    logic                  frame_start, silent;
    logic                  lrck_nxt, sdata_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counters idle at zero so that leaving IDLE is itself a frame start.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        bit_nxt     = bit_cnt;
        frame_start = 1'b0;
        silent      = 1'b0;
        case (state)
            IDLE: begin
                div_nxt = '0;
                bit_nxt = '0;
                if (enable) frame_start = 1'b1;
            end
            default: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
                        if (enable) frame_start = 1'b1;
                        else        state_nxt   = IDLE;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
                if (state == RD)         state_nxt = LATCH;
                else if (state == LATCH) state_nxt = WAIT;
            end
        endcase
        // Only pop when both sides have data, otherwise the channels would slip.
        if (frame_start) begin
            if (!l_empty && !r_empty) begin
                state_nxt = RD;
            end else begin
                state_nxt = WAIT;
                silent    = 1'b1;
            end
        end
    end

    // Serial outputs are computed from next-state counters and registered.
    always_comb begin
        lrck_nxt  = (bit_nxt >= SLOT);
        pos       = lrck_nxt ? (bit_nxt - SLOT) : bit_nxt;
        word      = lrck_nxt ? r_word : l_word;
        sdata_nxt = 1'b0;
        if (pos != '0 && pos <= DW)
            sdata_nxt = word[IDX_W'(DATA_WIDTH - int'(pos))];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            l_word       <= '0;
            r_word       <= '0;
            l_rd_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            i2s_bclk     <= 1'b0;
            i2s_lrck     <= 1'b0;
            i2s_sdata    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            i2s_bclk  <= (div_nxt >= DIV_HALF);
            i2s_lrck  <= lrck_nxt;
            i2s_sdata <= sdata_nxt;
            l_rd_en   <= (state_nxt == RD);
            r_rd_en   <= (state_nxt == RD);
            underrun  <= silent;
            if (silent) begin
                l_word <= '0;
                r_word <= '0;
                if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end else if (state == LATCH) begin
                l_word <= l_rd_data;
                r_word <= r_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx (BCLK_DIV=4, SLOT_BITS=32): FIFO model,
// frame capture on the falling clock, hand-computed expected frames.
module tb_i2s_stereo_tx;
    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [23:0] l_rd_data = '0, r_rd_data = '0;
    logic        l_empty, r_empty, l_rd_en, r_rd_en;
    logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun;
    logic [15:0] underrun_cnt;

    i2s_stereo_tx #(.DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .l_rd_data(l_rd_data), .l_empty(l_empty), .l_rd_en(l_rd_en),
        .r_rd_data(r_rd_data), .r_empty(r_empty), .r_rd_en(r_rd_en),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;

    // FIFO model: read data appears the cycle after the pop strobe.
    logic [23:0] lmem [0:15];
    logic [23:0] rmem [0:15];
    int lwr = 0, lrd = 0, rwr = 0, rrd = 0;
    assign l_empty = (lwr == lrd);
    assign r_empty = (rwr == rrd);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (l_rd_en) begin l_rd_data <= lmem[lrd % 16]; lrd <= lrd + 1; end
        if (r_rd_en) begin r_rd_data <= rmem[rrd % 16]; rrd <= rrd + 1; end
    end

    int pops[$];
    int pop_err = 0, ur_pulses = 0;
    logic rd_prev = 1'b0;
    always @(negedge clk) begin
        if (l_rd_en === 1'b1) pops.push_back(cyc);
        if (l_rd_en !== r_rd_en || (l_rd_en === 1'b1 && rd_prev)) pop_err++;
        if (underrun === 1'b1) ur_pulses++;
        rd_prev = (l_rd_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        lmem[lwr % 16] = l; lwr++;
        rmem[rwr % 16] = r; rwr++;
    endtask

    function automatic logic [63:0] fexp(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // Called at the falling edge just before the frame-start edge; returns there
    // one frame later. Bit k is sampled half a cycle after its boundary edge.
    task automatic run_frame(output logic [63:0] bits, output int shape_err, input int drop_at);
        bits = '0;
        shape_err = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            bits[63-k] = i2s_sdata;
            if (i2s_lrck !== (k >= 32)) shape_err++;
            if (i2s_bclk !== 1'b0) shape_err++;
            if (k == drop_at) enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
            if (i2s_bclk !== 1'b1) shape_err++;
            @(negedge clk);
        end
    endtask

    logic [63:0] bits;
    int se, e_cyc, p0, u0;
    logic [23:0] pl [3] = '{24'h111111, 24'h800001, 24'hC3C3C3};
    logic [23:0] pr [3] = '{24'hEEEEEE, 24'h7FFFFE, 24'h3C3C3C};

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_outs", {58'd0, i2s_bclk, i2s_lrck, i2s_sdata, l_rd_en, r_rd_en, underrun}, 64'd0);
        chk("rst_cnt", {48'd0, underrun_cnt}, 64'd0);
        chk("rst_pops", pops.size(), 0);

        // Single frame
        enable = 1'b0;
        rst_n  = 1'b1;
        push(24'hA5A5A5, 24'h5A5A5A);
        @(negedge clk);
        enable = 1'b1;
        e_cyc  = cyc + 1;
        run_frame(bits, se, -1);
        enable = 1'b0;
        chk("f1_data", bits, fexp(24'hA5A5A5, 24'h5A5A5A));
        chk("f1_shape", se, 0);
        chk("f1_npop", pops.size(), 1);
        chk("f1_popcyc", pops[0], e_cyc);
        chk("f1_ucnt", {48'd0, underrun_cnt}, 64'd0);
        repeat (20) @(negedge clk);
        chk("f1_idle", {62'd0, i2s_bclk, i2s_lrck}, 64'd0);
        chk("f1_npop_idle", pops.size(), 1);

        // Partial underrun: left has data, right empty
        lmem[lwr % 16] = 24'h123456; lwr++;
        @(negedge clk);
        enable = 1'b1;
        p0 = pops.size();
        u0 = ur_pulses;
        run_frame(bits, se, -1);
        rmem[rwr % 16] = 24'h0000FF; rwr++;
        chk("ur_data", bits, 64'd0);
        chk("ur_cnt", {48'd0, underrun_cnt}, 64'd1);
        chk("ur_pulse", ur_pulses - u0, 1);
        chk("ur_nopop", pops.size(), p0);
        run_frame(bits, se, -1);
        for (int i = 0; i < 3; i++) push(pl[i], pr[i]);
        chk("ur_fill_data", bits, fexp(24'h123456, 24'h0000FF));
        chk("ur_fill_pop", pops.size(), p0 + 1);

        // Continuous stream of three pairs, then a silent frame
        for (int i = 0; i < 3; i++) begin
            run_frame(bits, se, -1);
            chk($sformatf("cont%0d_data", i), bits, fexp(pl[i], pr[i]));
            chk($sformatf("cont%0d_shape", i), se, 0);
        end
        chk("cont_npop", pops.size(), p0 + 4);
        chk("cont_gap0", pops[p0+1] - pops[p0], 256);
        chk("cont_gap1", pops[p0+2] - pops[p0+1], 256);
        chk("cont_gap2", pops[p0+3] - pops[p0+2], 256);
        run_frame(bits, se, -1);
        push(24'hFFFFFF, 24'h000001);
        push(24'h0F0F0F, 24'hF0F0F0);
        chk("cont_silent", bits, 64'd0);
        chk("cont_ucnt", {48'd0, underrun_cnt}, 64'd2);

        // Enable dropped at bit 20: frame still completes, then IDLE without popping
        p0 = pops.size();
        run_frame(bits, se, 20);
        chk("drop_data", bits, fexp(24'hFFFFFF, 24'h000001));
        chk("drop_shape", se, 0);
        repeat (600) @(negedge clk);
        chk("drop_npop", pops.size(), p0 + 1);
        chk("drop_idle", {61'd0, i2s_bclk, i2s_lrck, i2s_sdata}, 64'd0);
        chk("drop_ucnt", {48'd0, underrun_cnt}, 64'd2);

        // Reset at bit 40 of a streaming frame
        enable = 1'b1;
        repeat (161) @(negedge clk);
        chk("mid_lrck", {63'd0, i2s_lrck}, 64'd1);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("mid_rst_outs", {58'd0, i2s_bclk, i2s_lrck, i2s_sdata, l_rd_en, r_rd_en, underrun}, 64'd0);
        chk("mid_rst_cnt", {48'd0, underrun_cnt}, 64'd0);
        push(24'hDEADBE, 24'h123ABC);
        p0 = pops.size();
        rst_n  = 1'b1;
        enable = 1'b1;
        run_frame(bits, se, -1);
        enable = 1'b0;
        chk("restart_data", bits, fexp(24'hDEADBE, 24'h123ABC));
        chk("restart_shape", se, 0);
        chk("restart_npop", pops.size(), p0 + 1);
        repeat (10) @(negedge clk);
        chk("pop_pairing", pop_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
